// File: rtl/bus_turnaround_arbiter.sv
// Two-requester round-robin arbiter for one shared bidirectional data bus.
// Turnaround cycles with the bus released are inserted on every direction change.
module bus_turnaround_arbiter #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [1:0]        Req_Sig,
  input  logic [1:0]        Req_Wr,
  input  logic [DATA_W-1:0] Req_WData0,
  input  logic [DATA_W-1:0] Req_WData1,
  output logic [1:0]        Grant,
  output logic [1:0]        Done_Sig,
  output logic [DATA_W-1:0] RData,
  output logic              Bus_Oe,
  inout  wire  [DATA_W-1:0] Data,
  output logic              ext_clk
);

  typedef enum logic [1:0] {StIdle, StTurn, StXfer, StDone} state_e;

  localparam logic [1:0] TaLast = 2'(TA_CYCLES - 1);

  state_e              state_q;
  logic                id_q;
  logic                wr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ptr_q;
  logic                last_wr_q;
  logic [1:0]          ta_cnt_q;
  logic [1:0]          grant_q;
  logic [1:0]          done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                oe_q;

  logic                win_id;
  logic                win_wr;
  logic [DATA_W-1:0]   win_data;

  // A lone request wins outright; a tie goes to the priority pointer.
  always_comb begin
    win_id = 1'b0;
    if (Req_Sig == 2'b11) begin
      win_id = ptr_q;
    end else if (Req_Sig == 2'b10) begin
      win_id = 1'b1;
    end
    win_wr   = Req_Wr[win_id];
    win_data = win_id ? Req_WData1 : Req_WData0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= StIdle;
      id_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      ptr_q     <= 1'b0;
      last_wr_q <= 1'b0;
      ta_cnt_q  <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      oe_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|Req_Sig) begin
            id_q     <= win_id;
            wr_q     <= win_wr;
            wdata_q  <= win_data;
            grant_q  <= win_id ? 2'b10 : 2'b01;
            ta_cnt_q <= '0;
            if (win_wr != last_wr_q) begin
              state_q <= StTurn;
            end else begin
              state_q <= StXfer;
              oe_q    <= win_wr;
            end
          end
        end
        StTurn: begin
          if (ta_cnt_q == TaLast) begin
            state_q  <= StXfer;
            oe_q     <= wr_q;
            ta_cnt_q <= '0;
          end else begin
            ta_cnt_q <= ta_cnt_q + 2'd1;
          end
        end
        StXfer: begin
          if (!wr_q) begin
            rdata_q <= Data;
          end
          last_wr_q <= wr_q;
          oe_q      <= 1'b0;
          done_q    <= grant_q;
          state_q   <= StDone;
        end
        StDone: begin
          done_q  <= '0;
          grant_q <= '0;
          ptr_q   <= ~id_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Grant    = grant_q;
  assign Done_Sig = done_q;
  assign RData    = rdata_q;
  assign Bus_Oe   = oe_q;
  assign Data     = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign ext_clk  = CLK;

endmodule
